apb_rr_master_arb: RTL

//  Round-robin arbiter + APB master sequencer sharing one APB slave (register file) among N requesters.

---
 rtl/apb_rr_master_arb.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/apb_rr_master_arb.sv
// apb_rr_master_arb
// Round-robin arbiter in front of a single-outstanding APB master. N command
// sources share one APB slave; each granted command runs SETUP then ACCESS,
// and the owning source receives a one-cycle response pulse carrying read
// data or a timeout error.
//
// Handshake semantics (command side): a requester raises req_valid_i[i] with
// its write/addr/wdata fields and holds them stable until it sees
// req_ready_o[i]=1 on a rising edge; that edge is the transfer. Dropping valid
// before the grant withdraws the command with no effect. req_ready_o is a
// combinational one-hot pulse, only ever raised while the sequencer is idle.
// The response side has no back-pressure: rsp_valid_o is a one-cycle one-hot
// pulse to the owner and rsp_rdata_o/rsp_err_o are meaningful only with it.
module apb_rr_master_arb #(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ-1:0]        req_write_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      m_psel_o,
   output logic                      m_penable_o,
   output logic                      m_pwrite_o,
   output logic [ADDR_W-1:0]         m_paddr_o,
   output logic [DATA_W-1:0]         m_pwdata_o,
   input  logic [DATA_W-1:0]         m_prdata_i,
   input  logic                      m_pready_i
);

   // Index width for requester numbers; a single requester still needs one bit.
   localparam int GW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   // Wait counter width; one bit is kept when the timeout is disabled.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   // Pointer value after reset so that requester 0 wins the first search.
   localparam logic [GW-1:0]    LAST_RST = GW'(NUM_REQ - 1);
   // Counter value seen in the final allowed ACCESS cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
   // Saturation value so the counter never wraps when the timeout is disabled.
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       last_grant_q, last_grant_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]   paddr_q, paddr_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic                psel_q, psel_d;
   logic                penable_q, penable_d;
   logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                rsp_err_q, rsp_err_d;

   logic                grant_found;
   logic [GW-1:0]       grant_idx;
   logic [GW-1:0]       cand_idx;
   logic                accept;
   logic                sel_write;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;
   logic [NUM_REQ-1:0]  owner_vec;
   logic                timeout_hit;

   // Round-robin search: first valid requester after the last grant, wrapping at NUM_REQ.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand_idx = GW'((int'(last_grant_q) + 1 + i) % NUM_REQ);
         if (!grant_found && req_valid_i[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // A grant is only offered while idle and never while reset is being applied.
   assign accept = (state_q == ST_IDLE) && grant_found && !rst_i;

   // Select the winner's command fields and raise its one-hot ready.
   always_comb begin
      sel_write   = 1'b0;
      sel_addr    = '0;
      sel_wdata   = '0;
      req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == GW'(i)) begin
            sel_write      = req_write_i[i];
            sel_addr       = req_addr_i[i*ADDR_W +: ADDR_W];
            sel_wdata      = req_wdata_i[i*DATA_W +: DATA_W];
            req_ready_o[i] = accept;
         end
      end
   end

   // The last grant is also the owner of the transaction in flight.
   always_comb begin
      owner_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         owner_vec[i] = (last_grant_q == GW'(i));
      end
   end

   // Abort condition: the final allowed ACCESS cycle passes without pready.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   // Sequencer next-state and next-output logic; responses are single-cycle pulses.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      psel_d       = psel_q;
      penable_d    = penable_q;
      rsp_valid_d  = '0;
      rsp_rdata_d  = '0;
      rsp_err_d    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d      = ST_SETUP;
               last_grant_d = grant_idx;
               pwrite_d     = sel_write;
               paddr_d      = sel_addr;
               pwdata_d     = sel_wdata;
               psel_d       = 1'b1;
               penable_d    = 1'b0;
            end
         end
         ST_SETUP: begin
            // pready is deliberately ignored here.
            state_d   = ST_ACCESS;
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         ST_ACCESS: begin
            if (m_pready_i) begin
               state_d     = ST_IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = owner_vec;
               rsp_rdata_d = pwrite_q ? '0 : m_prdata_i;
            end else if (timeout_hit) begin
               state_d     = ST_IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               rsp_valid_d = owner_vec;
               rsp_err_d   = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any transaction without a response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         last_grant_q <= LAST_RST;
         cnt_q        <= '0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         rsp_valid_q  <= '0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         psel_q       <= psel_d;
         penable_q    <= penable_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign m_psel_o    = psel_q;
   assign m_penable_o = penable_q;
   assign m_pwrite_o  = pwrite_q;
   assign m_paddr_o   = paddr_q;
   assign m_pwdata_o  = pwdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;

endmodule
